// File: rtl/intf_unit.sv
`default_nettype none
// ============================================================================
// Module   : intf_unit
// Brief    : Single-bit status endpoint. Holds a set/clear/toggle status bit,
//            a saturating transition counter and a registered read port that
//            returns the status bit, the PARAM identifier, the func constant
//            or the transition count.
// Options  : INTF_UNIT_FUNC_EN - when defined, read select 2 returns 32'd5;
//            otherwise select 2 returns 0 with an error strobe.
// Revision : 1.0 - initial release
// ============================================================================
module intf_unit #(
  parameter int unsigned PARAM = 0,
  parameter int          CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  op_i,
  input  logic        op_en_i,
  output logic        val_o,
  input  logic        rd_req_i,
  input  logic [1:0]  rd_sel_i,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        rd_err_o
);

  localparam logic [1:0] c_OP_NONE   = 2'd0;
  localparam logic [1:0] c_OP_SET    = 2'd1;
  localparam logic [1:0] c_OP_CLEAR  = 2'd2;
  localparam logic [1:0] c_OP_TOGGLE = 2'd3;

  localparam logic [1:0] c_SEL_VAL   = 2'd0;
  localparam logic [1:0] c_SEL_PARAM = 2'd1;
  localparam logic [1:0] c_SEL_FUNC  = 2'd2;
  localparam logic [1:0] c_SEL_CNT   = 2'd3;

  localparam logic [31:0]      c_PARAM   = 32'(PARAM);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic             val_q, val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_err_q, rd_err_d;

  // The func query is a fixed constant; without the feature it reads as an error.
  logic [31:0] w_func_data;
  logic        w_func_err;
`ifdef INTF_UNIT_FUNC_EN
  assign w_func_data = 32'd5;
  assign w_func_err  = 1'b0;
`else
  assign w_func_data = 32'd0;
  assign w_func_err  = 1'b1;
`endif

  // Next status bit from the qualified write operation.
  always_comb begin
    val_d = val_q;
    if (op_en_i) begin
      case (op_i)
        c_OP_SET:    val_d = 1'b1;
        c_OP_CLEAR:  val_d = 1'b0;
        c_OP_TOGGLE: val_d = ~val_q;
        c_OP_NONE:   val_d = val_q;
        default:     val_d = val_q;
      endcase
    end
  end

  // Count real transitions of the status bit, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if ((val_d != val_q) && (cnt_q != c_CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Read mux over current-cycle state, so a same-cycle write is not visible.
  always_comb begin
    rd_valid_d = rd_req_i;
    rd_data_d  = rd_data_q;
    rd_err_d   = 1'b0;
    if (rd_req_i) begin
      case (rd_sel_i)
        c_SEL_VAL:   rd_data_d = {31'd0, val_q};
        c_SEL_PARAM: rd_data_d = c_PARAM;
        c_SEL_FUNC: begin
          rd_data_d = w_func_data;
          rd_err_d  = w_func_err;
        end
        c_SEL_CNT:   rd_data_d = 32'(cnt_q);
        default:     rd_data_d = 32'd0;
      endcase
    end
  end

  // State and read-response registers; reset discards any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q      <= 1'b0;
      cnt_q      <= '0;
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      val_q      <= val_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign val_o      = val_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_err_o   = rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_intf_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_intf_unit
// Brief    : Directed self-checking bench for intf_unit. Two instances share
//            stimulus: u_main (PARAM=1, CNT_W=8) and u_sat (PARAM=7, CNT_W=2).
//            Honours INTF_UNIT_FUNC_EN for the select-2 expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intf_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  op;
  logic        op_en;
  logic        rd_req;
  logic [1:0]  rd_sel;

  logic        m_val, m_rd_valid, m_rd_err;
  logic [31:0] m_rd_data;
  logic        s_val, s_rd_valid, s_rd_err;
  logic [31:0] s_rd_data;

  int n_pass;
  int n_total;

`ifdef INTF_UNIT_FUNC_EN
  localparam logic [31:0] c_EXP_FUNC = 32'd5;
  localparam logic [31:0] c_EXP_FERR = 32'd0;
`else
  localparam logic [31:0] c_EXP_FUNC = 32'd0;
  localparam logic [31:0] c_EXP_FERR = 32'd1;
`endif

  intf_unit #(.PARAM(1), .CNT_W(8)) u_main (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_i       (op),
    .op_en_i    (op_en),
    .val_o      (m_val),
    .rd_req_i   (rd_req),
    .rd_sel_i   (rd_sel),
    .rd_data_o  (m_rd_data),
    .rd_valid_o (m_rd_valid),
    .rd_err_o   (m_rd_err)
  );

  intf_unit #(.PARAM(7), .CNT_W(2)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_i       (op),
    .op_en_i    (op_en),
    .val_o      (s_val),
    .rd_req_i   (rd_req),
    .rd_sel_i   (rd_sel),
    .rd_data_o  (s_rd_data),
    .rd_valid_o (s_rd_valid),
    .rd_err_o   (s_rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run is a fixed directed sequence and must finish well before this.
  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got timeout, need finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  // One write op, then check val on both instances at the following negedge.
  task automatic do_op(input logic [1:0] o, input logic exp_val, input string tag);
    @(negedge clk);
    op_en = 1'b1;
    op    = o;
    @(negedge clk);
    op_en = 1'b0;
    op    = 2'd0;
    check({tag, " main val"}, {31'd0, m_val}, {31'd0, exp_val});
    check({tag, " sat val"},  {31'd0, s_val}, {31'd0, exp_val});
  endtask

  // Single-cycle read request; response checked one cycle later on u_main.
  task automatic do_read(input logic [1:0] s, input logic [31:0] exp_data,
                         input logic [31:0] exp_err, input string tag);
    @(negedge clk);
    rd_req = 1'b1;
    rd_sel = s;
    @(negedge clk);
    rd_req = 1'b0;
    check({tag, " valid"}, {31'd0, m_rd_valid}, 32'd1);
    check({tag, " data"},  m_rd_data, exp_data);
    check({tag, " err"},   {31'd0, m_rd_err}, exp_err);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    op      = 2'd0;
    op_en   = 1'b0;
    rd_req  = 1'b0;
    rd_sel  = 2'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst val",      {31'd0, m_val}, 32'd0);
    check("rst rd_valid", {31'd0, m_rd_valid}, 32'd0);
    check("rst rd_data",  m_rd_data, 32'd0);
    check("rst rd_err",   {31'd0, m_rd_err}, 32'd0);
    rst_n = 1'b1;

    // Identity and func reads.
    do_read(2'd0, 32'd0, 32'd0, "rd sel0");
    // rd_data holds and rd_valid drops once the request is gone.
    @(negedge clk);
    check("rd_valid one-shot", {31'd0, m_rd_valid}, 32'd0);
    do_read(2'd1, 32'd1, 32'd0, "rd sel1");
    @(negedge clk);
    check("rd_data hold", m_rd_data, 32'd1);
    check("sat param",    s_rd_data, 32'd7);
    do_read(2'd2, c_EXP_FUNC, c_EXP_FERR, "rd sel2");
    do_read(2'd3, 32'd0, 32'd0, "rd cnt init");

    // set, set, toggle, toggle, clear -> 1,1,0,1,0 ; four real transitions.
    do_op(2'd1, 1'b1, "op set1");
    do_op(2'd1, 1'b1, "op set2");
    do_op(2'd3, 1'b0, "op tog1");
    do_op(2'd3, 1'b1, "op tog2");
    do_op(2'd2, 1'b0, "op clr");
    do_read(2'd3, 32'd4, 32'd0, "rd cnt seq");
    check("sat cnt seq", s_rd_data, 32'd3);

    // op_en low: op ignored.
    @(negedge clk);
    op = 2'd1;
    @(negedge clk);
    op = 2'd0;
    check("op_en gate", {31'd0, m_val}, 32'd0);

    // Five toggles: u_main 4 -> 9, u_sat stays saturated at 3.
    for (int i = 0; i < 5; i++) begin
      do_op(2'd3, (i % 2 == 0) ? 1'b1 : 1'b0, "op tog5");
    end
    do_read(2'd3, 32'd9, 32'd0, "rd cnt tog5");
    check("sat cnt tog5", s_rd_data, 32'd3);

    // val is 1; clear to 0 (count 10), then clear again (no count).
    do_op(2'd2, 1'b0, "op clr2");
    do_op(2'd2, 1'b0, "op clr3");

    // Same-cycle set + read sel0 returns pre-update value.
    @(negedge clk);
    op_en  = 1'b1;
    op     = 2'd1;
    rd_req = 1'b1;
    rd_sel = 2'd0;
    @(negedge clk);
    op_en  = 1'b0;
    op     = 2'd0;
    rd_req = 1'b0;
    check("same-cycle data",  m_rd_data, 32'd0);
    check("same-cycle valid", {31'd0, m_rd_valid}, 32'd1);
    check("same-cycle val",   {31'd0, m_val}, 32'd1);
    do_read(2'd0, 32'd1, 32'd0, "rd after set");

    // Back-to-back requests: sel3 then sel1 on consecutive cycles.
    @(negedge clk);
    rd_req = 1'b1;
    rd_sel = 2'd3;
    @(negedge clk);
    rd_sel = 2'd1;
    check("b2b0 valid", {31'd0, m_rd_valid}, 32'd1);
    check("b2b0 data",  m_rd_data, 32'd11);
    @(negedge clk);
    rd_req = 1'b0;
    check("b2b1 valid", {31'd0, m_rd_valid}, 32'd1);
    check("b2b1 data",  m_rd_data, 32'd1);
    @(negedge clk);
    check("b2b end", {31'd0, m_rd_valid}, 32'd0);

    // Reset with a response in flight: everything clears immediately.
    @(negedge clk);
    rd_req = 1'b1;
    rd_sel = 2'd1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mid-rst valid", {31'd0, m_rd_valid}, 32'd0);
    check("mid-rst data",  m_rd_data, 32'd0);
    check("mid-rst err",   {31'd0, m_rd_err}, 32'd0);
    check("mid-rst val",   {31'd0, m_val}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post-rst valid", {31'd0, m_rd_valid}, 32'd0);
    end
    do_read(2'd3, 32'd0, 32'd0, "rd cnt post-rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/intf_unit.md
# intf_unit

Parameterized single-bit status endpoint that packages the shared `val` signal, an instance parameter, and a constant query result (5) behind a registered read port. Consumer blocks instantiate it, singly or as a one-element array, to publish a status bit. Peers sample `val` directly or read identity and diagnostic data through the read port.

## Interface
Parameters:
- `PARAM`, default 0, instance identifier; 32-bit unsigned value returned by read select 1.
- `CNT_W`, default 8, width of the `val` transition counter (2..16).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  2  write operation: 0 = none, 1 = set, 2 = clear, 3 = toggle.
- `op_en`  in  1  qualifies `op`.
- `val`  out  1  registered status bit.
- `rd_req`  in  1  read request strobe.
- `rd_sel`  in  2  read select: 0 = val, 1 = PARAM, 2 = func, 3 = transition count.
- `rd_data`  out  32  read data, valid when `rd_valid` is high.
- `rd_valid`  out  1  one-cycle read response strobe.
- `rd_err`  out  1  one-cycle error strobe, coincident with `rd_valid`.

## Operation
- `val` update when `op_en` = 1:
  - set: `val` <- 1.
  - clear: `val` <- 0.
  - toggle: `val` <- ~`val`.
  - none: hold.
- With `op_en` = 0, `val` holds.
- Transition counter increments by 1 whenever the next `val` differs from the current `val`.
  - Saturates at 2^CNT_W−1; never wraps.
  - Set while already 1, or clear while already 0, does not count.
- Read data by `rd_sel`, all zero-extended to 32 bits:
  - 0: `val`.
  - 1: `PARAM`.
  - 2: constant 5 (the func query).
  - 3: transition counter.
- Read and write in the same cycle: the read returns the pre-update (current-cycle) state.
- `rd_err` asserts only for `rd_sel` = 2 when the func feature is compiled out. In that case `rd_data` = 0.
- No backpressure: every `rd_req` produces exactly one response. Back-to-back requests give back-to-back responses.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - `val` = 0, counter = 0.
  - `rd_data` = 0, `rd_valid` = 0, `rd_err` = 0.
- `val` changes on the first rising edge after `op_en` is sampled high. Latency is 1 cycle.
- Read response: `rd_valid`, `rd_data` and `rd_err` are registered and appear 1 cycle after `rd_req` is sampled.
  - `rd_valid` is high for exactly one cycle per request.
  - `rd_data` holds its last value when `rd_valid` is low.
- Reset asserted mid-read: the pending response is discarded. No `rd_valid` appears after reset releases.

## Configuration
- `INTF_UNIT_FUNC_EN` defined:
  - `rd_sel` = 2 returns 32'd5 with `rd_err` = 0.
- Not defined:
  - `rd_sel` = 2 returns 0 with `rd_err` = 1.
  - The constant-query logic is absent.
- All other behaviour is identical in both builds.

## Test plan
- Reset with `PARAM` = 1 -> `val` = 0, `rd_valid` = 0. Read sel 0 -> `rd_data` = 0. Read sel 1 -> `rd_data` = 1.
- Macro defined, read sel 2 -> `rd_data` = 5, `rd_err` = 0, one cycle after the request. Macro undefined -> `rd_data` = 0, `rd_err` = 1.
- Sequence set, set, toggle, toggle, clear -> `val` = 1, 1, 0, 1, 0 on successive cycles. Read sel 3 -> 4.
- `CNT_W` = 2, apply 5 toggles -> counter reads 3 (saturated).
- Same-cycle set and read sel 0 with `val` = 0 -> `rd_data` = 0; the next read returns 1.
- Drop `rst_n` with a read pending -> all outputs 0 immediately. No `rd_valid` after release.
